// File: rtl/div_seq_param_if.sv
// rtl/div_seq_param_if.sv - operand/result/handshake bundle for the sequential divider
interface div_seq_param_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             DivIn;
    logic             Signed;
    logic [WIDTH-1:0] resultHigh;
    logic [WIDTH-1:0] resultLow;
    logic             DivStop;
    logic             DivZero;
    logic             Busy;

    modport master (
        output A, B, DivIn, Signed,
        input  resultHigh, resultLow, DivStop, DivZero, Busy
    );

    modport slave (
        input  A, B, DivIn, Signed,
        output resultHigh, resultLow, DivStop, DivZero, Busy
    );
endinterface

// File: rtl/div_seq_param.sv
// rtl/div_seq_param.sv - restoring divider, one quotient bit per clock, signed/unsigned
// Quotient on resultLow, remainder on resultHigh; divide-by-zero reported without entering CALC.
module div_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                Reset,
    div_seq_param_if.slave      bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [CW-1:0]    cnt;
    logic             q_neg, r_neg;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             stop_q, zero_q;

    logic             start, zero_req, finish, last_step, busy;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_step, quo_step;

    // Magnitudes only in signed mode; -x of the most negative value yields the correct unsigned magnitude.
    assign abs_a = (bus.Signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign abs_b = (bus.Signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // rem < dvsr keeps shifted below 2*dvsr, so diff[WIDTH] is exactly the borrow of the trial subtract.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvsr};
    assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_step = {quo[WIDTH-2:0], ~diff[WIDTH]};

    assign last_step = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.DivIn && (bus.B != '0)) next_state = CALC;
            CALC:    if (last_step) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        zero_req = 1'b0;
        finish   = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                start    = bus.DivIn && (bus.B != '0);
                zero_req = bus.DivIn && (bus.B == '0);
            end
            CALC: begin
                busy   = 1'b1;
                finish = last_step;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
            stop_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            stop_q <= finish | zero_req;
            zero_q <= zero_req;
            if (start) begin
                rem   <= '0;
                quo   <= abs_a;
                dvsr  <= abs_b;
                cnt   <= CW'(WIDTH);
                q_neg <= bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                r_neg <= bus.Signed & bus.A[WIDTH-1];
            end else if (busy) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt - 1'b1;
                if (last_step) begin
                    res_lo <= q_neg ? -quo_step : quo_step;
                    res_hi <= r_neg ? -rem_step : rem_step;
                end
            end
        end
    end

    assign bus.resultHigh = res_hi;
    assign bus.resultLow  = res_lo;
    assign bus.DivStop    = stop_q;
    assign bus.DivZero    = zero_q;
    assign bus.Busy       = busy;
endmodule

// File: tb/tb_div_seq_param.sv
// tb/tb_div_seq_param.sv - directed vectors for div_seq_param at WIDTH=32 and WIDTH=8
module tb_div_seq_param;
    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    div_seq_param_if #(.WIDTH(32)) b32();
    div_seq_param_if #(.WIDTH(8))  b8();

    div_seq_param #(.WIDTH(32)) dut32 (.clk(clk), .Reset(Reset), .bus(b32));
    div_seq_param #(.WIDTH(8))  dut8  (.clk(clk), .Reset(Reset), .bus(b8));

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit disturb,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int edges;
        int busy_n;
        b32.A = a; b32.B = b; b32.Signed = s; b32.DivIn = 1'b1;
        tick();
        b32.DivIn = 1'b0;
        edges = 0;
        busy_n = 0;
        while (!b32.DivStop && edges < 100) begin
            if (b32.Busy) busy_n++;
            if (disturb && edges == 5) begin
                b32.A = 32'd1; b32.B = 32'd1; b32.Signed = ~s; b32.DivIn = 1'b1;
            end
            if (disturb && edges == 6) b32.DivIn = 1'b0;
            tick();
            edges++;
        end
        check({tag, " latency"}, 64'(edges), 64'd32);
        check({tag, " busy_cycles"}, 64'(busy_n), 64'd32);
        check({tag, " lo"}, 64'(b32.resultLow), 64'(exp_lo));
        check({tag, " hi"}, 64'(b32.resultHigh), 64'(exp_hi));
        check({tag, " divzero"}, 64'(b32.DivZero), 64'd0);
        tick();
        check({tag, " stop_pulse"}, 64'(b32.DivStop), 64'd0);
        check({tag, " lo_hold"}, 64'(b32.resultLow), 64'(exp_lo));
    endtask

    initial begin
        int stops;
        int edges;
        int pulses;

        Reset = 1'b0;
        b32.A = '0; b32.B = '0; b32.DivIn = 1'b0; b32.Signed = 1'b0;
        b8.A  = '0; b8.B  = '0; b8.DivIn  = 1'b0; b8.Signed  = 1'b0;
        tick();
        tick();
        check("rst lo", 64'(b32.resultLow), 64'd0);
        check("rst hi", 64'(b32.resultHigh), 64'd0);
        check("rst stop", 64'(b32.DivStop), 64'd0);
        check("rst zero", 64'(b32.DivZero), 64'd0);
        check("rst busy", 64'(b32.Busy), 64'd0);
        Reset = 1'b1;
        tick();

        run32("u100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2);

        b32.A = 32'd5; b32.B = 32'd0; b32.DivIn = 1'b1;
        tick();
        b32.DivIn = 1'b0;
        check("dz stop", 64'(b32.DivStop), 64'd1);
        check("dz zero", 64'(b32.DivZero), 64'd1);
        check("dz busy", 64'(b32.Busy), 64'd0);
        check("dz lo", 64'(b32.resultLow), 64'd14);
        check("dz hi", 64'(b32.resultHigh), 64'd2);
        tick();
        check("dz stop_clr", 64'(b32.DivStop), 64'd0);
        check("dz zero_clr", 64'(b32.DivZero), 64'd0);
        check("dz busy2", 64'(b32.Busy), 64'd0);

        run32("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run32("u-7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'h7FFF_FFFC, 32'd1);
        run32("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 32'd0);
        run32("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'h8000_0000);

        b32.A = 32'd100; b32.B = 32'd7; b32.Signed = 1'b0; b32.DivIn = 1'b1;
        tick();
        b32.DivIn = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        b32.A = 32'd1; b32.B = 32'd1; b32.DivIn = 1'b1;
        tick();
        b32.DivIn = 1'b0;
        for (int i = 6; i <= 9; i++) tick();
        check("abort busy_before", 64'(b32.Busy), 64'd1);
        Reset = 1'b0;
        tick();
        check("abort lo", 64'(b32.resultLow), 64'd0);
        check("abort hi", 64'(b32.resultHigh), 64'd0);
        check("abort busy", 64'(b32.Busy), 64'd0);
        check("abort stop", 64'(b32.DivStop), 64'd0);
        check("abort zero", 64'(b32.DivZero), 64'd0);
        Reset = 1'b1;
        stops = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (b32.DivStop) stops++;
        end
        check("abort no_stop", 64'(stops), 64'd0);
        run32("post_rst", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2);

        b8.A = 8'd200; b8.B = 8'd3; b8.Signed = 1'b0; b8.DivIn = 1'b1;
        tick();
        edges = 0;
        pulses = 0;
        while (pulses < 3 && edges < 100) begin
            tick();
            edges++;
            if (b8.DivStop) begin
                check("w8 stop_edge", 64'(edges), 64'(8 + 9 * pulses));
                check("w8 lo", 64'(b8.resultLow), 64'd66);
                check("w8 hi", 64'(b8.resultHigh), 64'd2);
                check("w8 zero", 64'(b8.DivZero), 64'd0);
                pulses++;
            end
        end
        check("w8 pulses", 64'(pulses), 64'd3);
        b8.DivIn = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
